// File: rtl/sd_pipeline_n.sv
// sd_pipeline_n: a chain of 2-entry skid stages. Every handshake and data output
// comes straight from a flop, so neither ready nor valid ripples along the chain.
module sd_pipeline_n_stage #(
  parameter int width = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             c_srdy_i,
  output logic             c_drdy_o,
  input  logic [width-1:0] c_data_i,
  output logic             p_srdy_o,
  input  logic             p_drdy_i,
  output logic [width-1:0] p_data_o
);

  // state | meaning
  // EMPTY | no word held; drdy=1 srdy=0
  // ONE   | output register valid; drdy=1 srdy=1
  // TWO   | output and skid registers valid; drdy=0 srdy=1
  // Encoding is {drdy, srdy}, so both handshake outputs are raw state flops.
  typedef enum logic [1:0] {EMPTY = 2'b10, ONE = 2'b11, TWO = 2'b01} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] data_q, data_d;
  logic [width-1:0] skid_q, skid_d;
  logic             in_xfer, out_xfer;

  assign c_drdy_o = state_q[1];
  assign p_srdy_o = state_q[0];
  assign p_data_o = data_q;
  assign in_xfer  = c_srdy_i & state_q[1];
  assign out_xfer = state_q[0] & p_drdy_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          data_d  = c_data_i;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          data_d = c_data_i;
        end else if (in_xfer) begin
          state_d = TWO;
          skid_d  = c_data_i;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_d = ONE;
          data_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Data registers keep stale contents; only the state says what is valid.
    if (flush_i) state_d = EMPTY;
  end

endmodule

module sd_pipeline_n #(
  parameter  int width = 16,
  parameter  int depth = 3,
  localparam int uw    = $clog2(2*depth+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [width-1:0] p_data,
  output logic [uw-1:0]    usage
);

  if (depth < 1 || depth > 8) begin : g_bad_depth
    $error("sd_pipeline_n: depth %0d outside 1..8", depth);
  end

  logic             srdy_w [depth+1];
  logic             drdy_w [depth+1];
  logic [width-1:0] data_w [depth+1];
  logic             c_xfer, p_xfer;
  logic [uw-1:0]    usage_q, usage_d;

  assign srdy_w[0]     = c_srdy;
  assign data_w[0]     = c_data;
  assign c_drdy        = drdy_w[0];
  assign p_srdy        = srdy_w[depth];
  assign p_data        = data_w[depth];
  assign drdy_w[depth] = p_drdy;

  for (genvar k = 0; k < depth; k++) begin : g_stage
    sd_pipeline_n_stage #(.width(width)) u_stage (
      .clk_i    (clk),
      .rst_n_i  (reset),
      .flush_i  (flush),
      .c_srdy_i (srdy_w[k]),
      .c_drdy_o (drdy_w[k]),
      .c_data_i (data_w[k]),
      .p_srdy_o (srdy_w[k+1]),
      .p_drdy_i (drdy_w[k+1]),
      .p_data_o (data_w[k+1])
    );
  end

  assign c_xfer = c_srdy & c_drdy;
  assign p_xfer = p_srdy & p_drdy;
  assign usage  = usage_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) usage_q <= '0;
    else        usage_q <= usage_d;
  end

  always_comb begin
    usage_d = usage_q;
    if (flush)                 usage_d = '0;
    else if (c_xfer && !p_xfer) usage_d = usage_q + uw'(1);
    else if (p_xfer && !c_xfer) usage_d = usage_q - uw'(1);
  end

endmodule

// File: tb/tb_sd_pipeline_n.sv
// Bench for sd_pipeline_n: four instances (depth 1,2,3,8) share one stimulus stream;
// each is checked every cycle against a queue model, plus directed literal checks.
module tb_sd_pipeline_n;
  localparam int W      = 16;
  localparam int N_INST = 4;

  logic         clk = 1'b0;
  logic         reset, flush, c_srdy, p_drdy;
  logic [W-1:0] c_data;

  logic         c_drdy_a [N_INST];
  logic         p_srdy_a [N_INST];
  logic [W-1:0] p_data_a [N_INST];
  logic [4:0]   usage_a  [N_INST];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < N_INST; g++) begin : g_inst
    localparam int D  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 8;
    localparam int UW = $clog2(2*D+1);
    logic [UW-1:0] usage_w;

    sd_pipeline_n #(.width(W), .depth(D)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .c_srdy (c_srdy),
      .c_drdy (c_drdy_a[g]),
      .c_data (c_data),
      .p_srdy (p_srdy_a[g]),
      .p_drdy (p_drdy),
      .p_data (p_data_a[g]),
      .usage  (usage_w)
    );
    assign usage_a[g] = 5'(usage_w);

    // Model: words accepted but not yet delivered, oldest first.
    logic [W-1:0] q[$];
    int           stall = 0;
    bit           seen = 0;
    bit           hold_prev = 0;
    logic [W-1:0] data_prev = '0;

    always @(negedge clk) begin
      if (!reset) begin
        q.delete();
        seen = 0;
        hold_prev = 0;
        stall = 0;
        check($sformatf("d%0d_rst_p_srdy", D), p_srdy_a[g], 0);
        check($sformatf("d%0d_rst_c_drdy", D), c_drdy_a[g], 1);
        check($sformatf("d%0d_rst_usage", D), usage_a[g], 0);
        check($sformatf("d%0d_rst_p_data", D), p_data_a[g], 0);
      end else begin
        check($sformatf("d%0d_usage", D), usage_a[g], q.size());
        if (q.size() == 0) begin
          check($sformatf("d%0d_empty_p_srdy", D), p_srdy_a[g], 0);
          check($sformatf("d%0d_empty_c_drdy", D), c_drdy_a[g], 1);
        end
        if (q.size() == 2*D) check($sformatf("d%0d_full_c_drdy", D), c_drdy_a[g], 0);
        if (p_srdy_a[g]) begin
          seen = 1;
          if (q.size() > 0) check($sformatf("d%0d_head_data", D), p_data_a[g], q[0]);
        end
        if (!seen) check($sformatf("d%0d_idle_p_data", D), p_data_a[g], 0);
        if (hold_prev) begin
          check($sformatf("d%0d_hold_p_srdy", D), p_srdy_a[g], 1);
          check($sformatf("d%0d_hold_p_data", D), p_data_a[g], data_prev);
        end
        if (q.size() > 0 && !p_srdy_a[g]) stall++;
        else stall = 0;
        if (q.size() > 0) check($sformatf("d%0d_progress", D), (stall < D), 1);

        hold_prev = p_srdy_a[g] && !p_drdy && !flush;
        data_prev = p_data_a[g];
        if (p_srdy_a[g] && p_drdy && q.size() > 0) void'(q.pop_front());
        if (flush) q.delete();
        else if (c_srdy && c_drdy_a[g]) q.push_back(c_data);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, expw, pc, pp, t;
    bit acc;
    logic [W-1:0] prev;
    logic [W-1:0] seq;

    reset = 1'b0; flush = 1'b0; c_srdy = 1'b0; p_drdy = 1'b0; c_data = '0;
    repeat (3) tick();
    check("reset_p_srdy", p_srdy_a[2], 0);
    check("reset_c_drdy", c_drdy_a[2], 1);
    check("reset_usage", usage_a[2], 0);
    check("reset_p_data", p_data_a[2], 0);
    reset = 1'b1;
    tick();

    // Single word latency through depth 3.
    c_srdy = 1'b1; c_data = 16'h00A5; p_drdy = 1'b1;
    tick();
    c_srdy = 1'b0; c_data = '0;
    check("lat_usage_e0", usage_a[2], 1);
    check("lat_p_srdy_e0", p_srdy_a[2], 0);
    tick();
    check("lat_p_srdy_e1", p_srdy_a[2], 0);
    tick();
    check("lat_p_srdy_e2", p_srdy_a[2], 1);
    check("lat_p_data_e2", p_data_a[2], 16'h00A5);
    check("lat_usage_e2", usage_a[2], 1);
    tick();
    check("lat_usage_e3", usage_a[2], 0);
    check("lat_p_srdy_e3", p_srdy_a[2], 0);

    // Fill under backpressure: depth 3 holds 6 words.
    p_drdy = 1'b0; c_srdy = 1'b1; idx = 1; c_data = 16'(idx);
    repeat (10) begin
      acc = c_drdy_a[2];
      tick();
      if (acc) begin idx++; c_data = 16'(idx); end
    end
    check("fill_accepted", idx - 1, 6);
    check("fill_usage", usage_a[2], 6);
    check("fill_c_drdy", c_drdy_a[2], 0);
    check("fill_p_data", p_data_a[2], 1);
    p_drdy = 1'b1; expw = 1; t = 0;
    while (expw <= 8 && t < 40) begin
      if (p_srdy_a[2]) begin
        check("drain_word", p_data_a[2], expw);
        expw++;
      end
      acc = c_drdy_a[2] && c_srdy;
      tick();
      t++;
      if (acc) begin
        if (idx == 8) c_srdy = 1'b0;
        else begin idx++; c_data = 16'(idx); end
      end
    end
    check("drain_count", expw, 9);
    c_srdy = 1'b0;
    repeat (12) tick();

    // Continuous streaming through depth 2.
    flush = 1'b1; tick(); flush = 1'b0;
    c_srdy = 1'b1; p_drdy = 1'b1; c_data = 16'h1000; prev = '0;
    for (int s = 0; s < 100; s++) begin
      tick();
      c_data = c_data + 16'd1;
      if (s >= 4) begin
        check("stream_p_srdy", p_srdy_a[1], 1);
        check("stream_usage", usage_a[1], 2);
        check("stream_c_drdy", c_drdy_a[1], 1);
      end
      if (s >= 5) check("stream_step", p_data_a[1], prev + 16'd1);
      prev = p_data_a[1];
    end
    c_srdy = 1'b0;
    repeat (12) tick();

    // Flush with four words held, simultaneous delivery and offered word.
    flush = 1'b1; tick(); flush = 1'b0;
    p_drdy = 1'b0; c_srdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_data = 16'h0200 + 16'(i);
      tick();
    end
    check("preflush_usage", usage_a[2], 4);
    check("preflush_p_data", p_data_a[2], 16'h0200);
    flush = 1'b1; p_drdy = 1'b1; c_data = 16'hBEEF;
    tick();
    flush = 1'b0; c_srdy = 1'b0;
    check("flush_usage", usage_a[2], 0);
    check("flush_p_srdy", p_srdy_a[2], 0);
    check("flush_c_drdy", c_drdy_a[2], 1);
    flush = 1'b1; c_srdy = 1'b1;
    repeat (3) begin
      tick();
      check("flush_hold_c_drdy", c_drdy_a[2], 1);
      check("flush_hold_usage", usage_a[2], 0);
    end
    flush = 1'b0; c_srdy = 1'b0;
    repeat (6) begin
      tick();
      check("flush_no_beef", p_srdy_a[2], 0);
    end

    // Randomized traffic with varying pressure and occasional flush.
    seq = 16'h2000;
    for (int seg = 0; seg < 10; seg++) begin
      pc = $urandom_range(10, 95);
      pp = $urandom_range(10, 95);
      for (int r = 0; r < 1000; r++) begin
        c_srdy = ($urandom_range(0, 99) < pc);
        p_drdy = ($urandom_range(0, 99) < pp);
        flush  = ($urandom_range(0, 299) == 0);
        c_data = seq;
        seq = seq + 16'd1;
        tick();
      end
    end
    flush = 1'b0; c_srdy = 1'b0;

    // Asynchronous reset mid-cycle with five words held.
    flush = 1'b1; tick(); flush = 1'b0;
    p_drdy = 1'b0; c_srdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c_data = 16'h0300 + 16'(i);
      tick();
    end
    c_srdy = 1'b0;
    check("prerst_usage", usage_a[2], 5);
    #2;
    reset = 1'b0;
    #1;
    check("async_p_srdy", p_srdy_a[2], 0);
    check("async_c_drdy", c_drdy_a[2], 1);
    check("async_usage", usage_a[2], 0);
    check("async_p_data", p_data_a[2], 0);
    tick();
    reset = 1'b1;
    c_srdy = 1'b1; c_data = 16'h0700; p_drdy = 1'b1;
    tick();
    c_srdy = 1'b0;
    check("post_rst_accept", usage_a[2], 1);
    t = 0;
    while (!p_srdy_a[2] && t < 10) begin tick(); t++; end
    check("post_rst_p_srdy", p_srdy_a[2], 1);
    check("post_rst_word", p_data_a[2], 16'h0700);
    repeat (12) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
